onn_phase_serializer: RTL and testbench

Transmit-side counterpart of the serial pixel loader feeding `control_to_neuron`. It captures the 60-bit parallel phase vector of the 3x5 ONN (15 neurons × 4-bit phase, `phi` ordering `[0:59]`) and shifts it out one bit per clock. The output stream uses the same nibble-serial, MSB-first format the network consumes. It sits between the oscillator array's `phi_out` and the off-chip/readback serial link, so a bench or host can rebuild the 5x3 phase matrix.

---
 rtl/onn_phase_serializer.sv | 165 ++++++++++++++++
 tb/tb_onn_phase_serializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onn_phase_serializer.sv
// onn_phase_serializer
//
// Transmit-side serializer for the 3x5 ONN phase vector. It captures the
// 60-bit parallel phase vector from the oscillator array and sends it one bit
// per clock. The stream is nibble-serial and MSB-first: neuron 0 goes first,
// and phi_in[4k] is bit 3 of neuron k. This is the same format the serial
// pixel loader feeds to control_to_neuron.
//
// Optional feature:
//   ONN_TX_PARITY_EN - when defined, one even-parity bit (the XOR of all 60
//                      captured bits) is appended after bit 59, and `last`
//                      marks that parity bit. When undefined, there is no
//                      parity state or accumulator, and `last` marks bit 59.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   load        in   frame request, only honoured while ready=1
//   phi_in      in   [0:FRAME_W-1] phase vector, captured on the accepted load edge
//   ready       out  high only while idle
//   bit_out     out  serial data (0 when idle)
//   bit_valid   out  bit_out carries a frame bit this cycle
//   frame_start out  high with the first bit of a frame
//   last        out  high with the final bit of a frame
//
// All outputs are registered, so there is no combinational input-to-output path.

module onn_phase_serializer #(
  parameter int unsigned N_NEURONS = 15,
  parameter int unsigned PHASE_W   = 4,
  localparam int unsigned FRAME_W  = N_NEURONS * PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [0:FRAME_W-1] phi_in,
  output logic               ready,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               frame_start,
  output logic               last
);

  localparam int unsigned CntW = $clog2(FRAME_W);
  localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_W - 1);
`ifndef ONN_TX_PARITY_EN
  localparam logic [CntW-1:0] PenIdx = CntW'(FRAME_W - 2);
`endif

`ifdef ONN_TX_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e              state_q;
  logic [FRAME_W-1:0]  sr_q;
  logic [CntW-1:0]     cnt_q;
  logic                ready_q;
  logic                bit_out_q;
  logic                bit_valid_q;
  logic                frame_start_q;
  logic                last_q;
`ifdef ONN_TX_PARITY_EN
  logic                par_q;
`endif

  // Remap the ascending-indexed port onto a descending vector. This keeps
  // phi_in[i] at sr bit i, so a right shift walks the frame in port order.
  logic [FRAME_W-1:0]  cap_vec;

  always_comb begin
    cap_vec = '0;
    for (int unsigned i = 0; i < FRAME_W; i++) begin
      cap_vec[i] = phi_in[i];
    end
  end

  // cnt_q holds the index of the bit currently on bit_out. Bit 0 is
  // presented straight from the capture edge, so sr_q keeps only the bits
  // still to come.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sr_q          <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      last_q        <= 1'b0;
`ifdef ONN_TX_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      frame_start_q <= 1'b0;
      last_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            state_q       <= StShift;
            sr_q          <= cap_vec >> 1;
            cnt_q         <= '0;
            ready_q       <= 1'b0;
            bit_out_q     <= cap_vec[0];
            bit_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
`ifdef ONN_TX_PARITY_EN
            par_q         <= cap_vec[0];
`endif
          end
        end

        StShift: begin
          if (cnt_q == LastIdx) begin
`ifdef ONN_TX_PARITY_EN
            // par_q already covers bits 0..59, including the one just sent.
            state_q     <= StPar;
            bit_out_q   <= par_q;
            bit_valid_q <= 1'b1;
            last_q      <= 1'b1;
`else
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
`endif
          end else begin
            bit_out_q <= sr_q[0];
            sr_q      <= sr_q >> 1;
            cnt_q     <= cnt_q + CntW'(1);
`ifdef ONN_TX_PARITY_EN
            par_q     <= par_q ^ sr_q[0];
`else
            last_q    <= (cnt_q == PenIdx);
`endif
          end
        end

`ifdef ONN_TX_PARITY_EN
        StPar: begin
          state_q     <= StIdle;
          ready_q     <= 1'b1;
          bit_out_q   <= 1'b0;
          bit_valid_q <= 1'b0;
        end
`endif

        default: begin
          state_q     <= StIdle;
          ready_q     <= 1'b1;
          bit_out_q   <= 1'b0;
          bit_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign last        = last_q;

endmodule

// File: tb/tb_onn_phase_serializer.sv
// Testbench for onn_phase_serializer.
//
// The bench keeps a frame-position model: it records the captured frame and
// the index of the bit expected on the wire. Every cycle it checks all five
// outputs against that model. Literal checks then pin the stream contents
// and the timing for each directed vector.

module tb_onn_phase_serializer;

  localparam int FW = 60;
`ifdef ONN_TX_PARITY_EN
  localparam int L = 61;
`else
  localparam int L = 60;
`endif

  logic          clk;
  logic          rst;
  logic          load;
  logic [0:FW-1] phi_in;
  logic          ready;
  logic          bit_out;
  logic          bit_valid;
  logic          frame_start;
  logic          last;

  onn_phase_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .phi_in     (phi_in),
    .ready      (ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .last       (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  // Model state: m_pos is the frame index on the wire, or -1 when idle.
  int          m_pos = -1;
  logic [0:FW] m_frame;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_compare();
    logic [4:0] exp_v;
    logic       eb;
    eb    = (m_pos >= 0) ? m_frame[m_pos] : 1'b0;
    exp_v = {m_pos < 0, m_pos >= 0, eb, m_pos == 0, m_pos == L - 1};
    chk("model_rdy_vld_bit_fs_last", {ready, bit_valid, bit_out, frame_start, last}, exp_v);
  endtask

  task automatic model_edge();
    if (rst) m_pos = -1;
    else if (m_pos < 0) begin
      if (load) begin
        m_frame = {phi_in, ^phi_in};
        m_pos   = 0;
      end
    end else if (m_pos == L - 1) m_pos = -1;
    else m_pos++;
  endtask

  // One clock: check at the falling edge, update the model at the rising edge,
  // and return 1 time unit after the edge so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    if (chk_en) model_compare();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
    if (!ready) chk("wait_ready_timeout", 64'(ready), 64'd1);
  endtask

  function automatic logic [0:FW-1] put_nib(input logic [0:FW-1] v, input int k,
                                           input logic [3:0] n);
    logic [0:FW-1] r;
    r = v;
    for (int j = 0; j < 4; j++) r[4*k+j] = n[3-j];
    return r;
  endfunction

  function automatic logic [3:0] get_nib(input logic [0:FW] g, input int k);
    return {g[4*k], g[4*k+1], g[4*k+2], g[4*k+3]};
  endfunction

  // Sends one frame and samples cycles T+1..T+L+1.
  task automatic send_frame(input logic [0:FW-1] v, output logic [0:FW] got,
                            output int fs_at, output int last_at, output int rdy_at,
                            output int n_valid);
    wait_ready();
    phi_in = v;
    load   = 1'b1;
    step();
    load    = 1'b0;
    got     = '0;
    fs_at   = -1;
    last_at = -1;
    rdy_at  = -1;
    n_valid = 0;
    for (int i = 0; i <= L; i++) begin
      if (bit_valid) begin
        n_valid++;
        if (i <= FW) got[i] = bit_out;
      end
      if (frame_start && fs_at < 0) fs_at = i;
      if (last && last_at < 0) last_at = i;
      if (ready && rdy_at < 0) rdy_at = i;
      step();
    end
  endtask

  logic [0:FW-1] va, vb, v;
  logic [0:FW]   got;
  int            fs_at, last_at, rdy_at, n_valid, fs_n, fs2, rdy_n, ones;

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    phi_in = '0;
    step();
    step();
    chk("reset_outputs", {ready, bit_valid, bit_out, frame_start, last}, 5'b10000);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Idle for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_outputs", {ready, bit_valid, bit_out}, 3'b100);
    end

    // Nibbles 8,8,0 repeated five times.
    v = '0;
    for (int k = 0; k < 15; k++) v = put_nib(v, k, (k % 3 == 2) ? 4'h0 : 4'h8);
    send_frame(v, got, fs_at, last_at, rdy_at, n_valid);
    chk("t880_fs_at", fs_at, 0);
    chk("t880_last_at", last_at, L - 1);
    chk("t880_ready_back", rdy_at, L);
    chk("t880_nvalid", n_valid, L);
    chk("t880_first12", {get_nib(got, 0), get_nib(got, 1), get_nib(got, 2)}, 12'h880);
    for (int k = 0; k < 15; k++)
      chk("t880_matrix", get_nib(got, k), (k % 3 == 2) ? 4'h0 : 4'h8);
`ifdef ONN_TX_PARITY_EN
    chk("t880_parity", got[60], 1'b0);
`endif

    // Neuron k carries phase k.
    v = '0;
    for (int k = 0; k < 15; k++) v = put_nib(v, k, 4'(k));
    send_frame(v, got, fs_at, last_at, rdy_at, n_valid);
    chk("tk_neuron0", get_nib(got, 0), 4'b0000);
    chk("tk_neuron5", {got[20], got[21], got[22], got[23]}, 4'b0101);
    chk("tk_neuron14", get_nib(got, 14), 4'b1110);
    chk("tk_last_at", last_at, L - 1);

    // All ones except phi_in[59].
    v = '1;
    v[59] = 1'b0;
    send_frame(v, got, fs_at, last_at, rdy_at, n_valid);
    ones = 0;
    for (int i = 0; i < 59; i++) ones += int'(got[i]);
    chk("t1s_ones", ones, 59);
    chk("t1s_bit59", got[59], 1'b0);
`ifdef ONN_TX_PARITY_EN
    chk("t1s_parity", got[60], 1'b1);
    chk("t1s_last_at", last_at, 60);
`else
    chk("t1s_last_at", last_at, 59);
`endif

    // Mid-frame load pulses and a phi_in change, then load held high.
    va = '0;
    vb = '1;
    for (int k = 0; k < 15; k++) va = put_nib(va, k, 4'(15 - k));
    wait_ready();
    phi_in = va;
    load   = 1'b1;
    step();
    load  = 1'b0;
    got   = '0;
    fs_n  = 0;
    fs2   = -1;
    rdy_n = 0;
    for (int i = 0; i < L + 4; i++) begin
      if (i < L) got[i] = bit_out;
      if (frame_start) begin
        fs_n++;
        if (i > 0 && fs2 < 0) fs2 = i;
      end
      if (ready) rdy_n++;
      phi_in = (i >= 4) ? vb : va;
      load   = (i == 9) || (i == 29) || (i >= 40);
      step();
    end
    load = 1'b0;
    chk("tmid_frame_bits", got[0:FW-1], va);
`ifdef ONN_TX_PARITY_EN
    chk("tmid_parity", got[60], ^va);
`endif
    chk("tmid_fs_count", fs_n, 2);
    chk("tmid_second_fs", fs2, L + 1);
    chk("tmid_ready_cycles", rdy_n, 1);
    wait_ready();

    // Reset mid-frame at T+20.
    phi_in = va;
    load   = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 19; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("trst_outputs", {ready, bit_valid, bit_out, frame_start, last}, 5'b10000);
    step();
    chk("trst_stays_idle", {ready, bit_valid}, 2'b10);
    send_frame(vb, got, fs_at, last_at, rdy_at, n_valid);
    chk("trst_fresh_fs", fs_at, 0);
    chk("trst_fresh_last", last_at, L - 1);
    chk("trst_fresh_bits", got[0:FW-1], vb);

    // Reset and load asserted together: reset wins.
    rst    = 1'b1;
    load   = 1'b1;
    phi_in = va;
    step();
    rst  = 1'b0;
    load = 1'b0;
    chk("trst_load_out", {ready, bit_valid, frame_start}, 3'b100);
    step();
    chk("trst_load_nocap", {ready, bit_valid}, 2'b10);

    for (int i = 0; i < 3; i++) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
